// File: rtl/golay24_dec_cand_metric_pkg.sv
// Golay(24,12) soft decoder: shared types and constants for the candidate-metric stage.
// Optional build macro GOLAY24_DEC_LLR_SYM_CLIP_EN is consumed by golay24_dec_cand_metric.
package golay24_dec_cand_metric_pkg;

    localparam int cDAT_W    = 24;
    localparam int cTREE_LAT = 3;
    localparam int cLLR_W    = 4;
    localparam int cMETRIC_W = cLLR_W + 6;
    localparam int cTAG_W    = 1;

    typedef logic [cDAT_W-1:0]           dat_t;
    typedef logic signed [cLLR_W-1:0]    llr_t;
    typedef logic signed [cMETRIC_W-1:0] metric_t;
    typedef logic [cTAG_W-1:0]           tag_t;

endpackage

// File: rtl/golay24_dec_metric_sum.sv
// 24-input two's-complement adder tree, 24->6->2->1, three register stages.
// Inputs must already be sign-extended to the result width.
module golay24_dec_metric_sum
    import golay24_dec_cand_metric_pkg::*;
#(
    parameter int pW = cMETRIC_W
)
(
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     iclkena,
    input  logic [cDAT_W-1:0][pW-1:0] idat,
    output logic [pW-1:0]            osum
);

    logic [5:0][pW-1:0] s1;
    logic [1:0][pW-1:0] s2;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            s1   <= '0;
            s2   <= '0;
            osum <= '0;
        end else if (iclkena) begin
            for (int i = 0; i < 6; i++) begin
                s1[i] <= idat[4*i] + idat[4*i+1] + idat[4*i+2] + idat[4*i+3];
            end
            for (int i = 0; i < 2; i++) begin
                s2[i] <= s1[3*i] + s1[3*i+1] + s1[3*i+2];
            end
            osum <= s2[0] + s2[1];
        end
    end

endmodule

// File: rtl/golay24_dec_cand_metric.sv
// Golay(24,12) ML decoder candidate-metric stage: frame hard decision, channel and candidate metrics.
// Build macro GOLAY24_DEC_LLR_SYM_CLIP_EN clips the most negative LLR code at load.
module golay24_dec_cand_metric
    import golay24_dec_cand_metric_pkg::*;
#(
    parameter int pLLR_W = 4,
    parameter int pTAG_W = 1,
    localparam int cM_W  = pLLR_W + 6
)
(
    input  logic                   iclk,
    input  logic                   ireset,
    input  logic                   iclkena,
    input  logic                   iload,
    input  logic [24*pLLR_W-1:0]   illr,
    input  logic [pTAG_W-1:0]      iltag,
    output logic                   ordy,
    input  logic                   isop,
    input  logic                   ival,
    input  logic                   ieop,
    input  dat_t                   icand_dat,
    output logic                   osop,
    output logic                   oval,
    output logic                   oeop,
    output logic [pTAG_W-1:0]      otag,
    output dat_t                   och_hd,
    output logic [cM_W-1:0]        och_metric,
    output dat_t                   ocand_dat,
    output logic [cM_W-1:0]        ocand_metric
);

    localparam int cEXT = cM_W - pLLR_W;
    localparam logic [pLLR_W-1:0] cLLR_MIN = {1'b1, {(pLLR_W-1){1'b0}}};
    localparam logic [pLLR_W-1:0] cLLR_SYM = cLLR_MIN | pLLR_W'(1);

    logic [cDAT_W-1:0][pLLR_W-1:0] llr_in;
    logic [cDAT_W-1:0][pLLR_W-1:0] llr_q;
    logic [cDAT_W-1:0][cM_W-1:0]   ch_abs;
    logic [cDAT_W-1:0][cM_W-1:0]   cand_term;
    logic [cDAT_W-1:0][cM_W-1:0]   term_q;
    dat_t                          hd_q;
    logic [pTAG_W-1:0]             tag_q;
    logic [1:0]                    win_cnt;
    logic [cM_W-1:0]               ch_metric;
    logic                          acc;

    logic [cTREE_LAT:0]            val_p;
    logic [cTREE_LAT:0]            sop_p;
    logic [cTREE_LAT:0]            eop_p;
    dat_t                          hd_p  [cTREE_LAT+1];
    dat_t                          dat_p [cTREE_LAT+1];
    logic [pTAG_W-1:0]             tag_p [cTREE_LAT+1];
    logic [cM_W-1:0]               chm_p [cTREE_LAT+1];

    function automatic logic [cM_W-1:0] sext(input logic [pLLR_W-1:0] v);
        return {{cEXT{v[pLLR_W-1]}}, v};
    endfunction

    always_comb begin
        llr_in = illr;
`ifdef GOLAY24_DEC_LLR_SYM_CLIP_EN
        for (int i = 0; i < cDAT_W; i++) begin
            if (llr_in[i] == cLLR_MIN) llr_in[i] = cLLR_SYM;
        end
`endif
    end

    // Extend before negating so the most negative code still negates exactly
    always_comb begin
        ch_abs    = '0;
        cand_term = '0;
        for (int i = 0; i < cDAT_W; i++) begin
            ch_abs[i]    = llr_q[i][pLLR_W-1] ? -sext(llr_q[i]) : sext(llr_q[i]);
            cand_term[i] = icand_dat[i]       ? -sext(llr_q[i]) : sext(llr_q[i]);
        end
    end

    assign acc = ival & ordy;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            llr_q   <= '0;
            hd_q    <= '0;
            tag_q   <= '0;
            win_cnt <= '0;
            ordy    <= 1'b0;
        end else if (iclkena) begin
            if (iload) begin
                llr_q   <= llr_in;
                tag_q   <= iltag;
                win_cnt <= 2'(cTREE_LAT);
                ordy    <= 1'b0;
                for (int i = 0; i < cDAT_W; i++) begin
                    hd_q[i] <= llr_in[i][pLLR_W-1];
                end
            end else if (win_cnt != 2'd0) begin
                win_cnt <= win_cnt - 2'd1;
                ordy    <= (win_cnt == 2'd1);
            end
        end
    end

    golay24_dec_metric_sum #(.pW(cM_W)) u_ch_sum (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .idat    (ch_abs),
        .osum    (ch_metric)
    );

    // Side fields ride alongside the candidate tree, so a reload never touches them
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            term_q <= '0;
            val_p  <= '0;
            sop_p  <= '0;
            eop_p  <= '0;
            for (int k = 0; k <= cTREE_LAT; k++) begin
                hd_p[k]  <= '0;
                dat_p[k] <= '0;
                tag_p[k] <= '0;
                chm_p[k] <= '0;
            end
        end else if (iclkena) begin
            term_q   <= cand_term;
            val_p    <= {val_p[cTREE_LAT-1:0], acc};
            sop_p    <= {sop_p[cTREE_LAT-1:0], isop & acc};
            eop_p    <= {eop_p[cTREE_LAT-1:0], ieop & acc};
            hd_p[0]  <= hd_q;
            dat_p[0] <= icand_dat;
            tag_p[0] <= tag_q;
            chm_p[0] <= ch_metric;
            for (int k = 1; k <= cTREE_LAT; k++) begin
                hd_p[k]  <= hd_p[k-1];
                dat_p[k] <= dat_p[k-1];
                tag_p[k] <= tag_p[k-1];
                chm_p[k] <= chm_p[k-1];
            end
        end
    end

    golay24_dec_metric_sum #(.pW(cM_W)) u_cand_sum (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .idat    (term_q),
        .osum    (ocand_metric)
    );

    assign oval       = val_p[cTREE_LAT];
    assign osop       = sop_p[cTREE_LAT];
    assign oeop       = eop_p[cTREE_LAT];
    assign otag       = tag_p[cTREE_LAT];
    assign och_hd     = hd_p[cTREE_LAT];
    assign ocand_dat  = dat_p[cTREE_LAT];
    assign och_metric = chm_p[cTREE_LAT];

endmodule

// File: tb/tb_golay24_dec_cand_metric.sv
// Bench for golay24_dec_cand_metric: directed frames plus randomized traffic vs a frame-level model.
`timescale 1ns/1ps
module tb_golay24_dec_cand_metric;

    localparam int W  = 4;
    localparam int MW = W + 6;

    logic              iclk = 1'b0;
    logic              ireset = 1'b1;
    logic              iclkena = 1'b0;
    logic              iload = 1'b0;
    logic [24*W-1:0]   illr = '0;
    logic [0:0]        iltag = '0;
    logic              ordy;
    logic              isop = 1'b0;
    logic              ival = 1'b0;
    logic              ieop = 1'b0;
    logic [23:0]       icand_dat = '0;
    logic              osop, oval, oeop;
    logic [0:0]        otag;
    logic [23:0]       och_hd, ocand_dat;
    logic [MW-1:0]     och_metric, ocand_metric;

    golay24_dec_cand_metric #(.pLLR_W(W), .pTAG_W(1)) dut (
        .iclk         (iclk),
        .ireset       (ireset),
        .iclkena      (iclkena),
        .iload        (iload),
        .illr         (illr),
        .iltag        (iltag),
        .ordy         (ordy),
        .isop         (isop),
        .ival         (ival),
        .ieop         (ieop),
        .icand_dat    (icand_dat),
        .osop         (osop),
        .oval         (oval),
        .oeop         (oeop),
        .otag         (otag),
        .och_hd       (och_hd),
        .och_metric   (och_metric),
        .ocand_dat    (ocand_dat),
        .ocand_metric (ocand_metric)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int due;
        int sop;
        int eop;
        int tag;
        int hd;
        int chm;
        int cm;
        int dat;
    } exp_t;

    exp_t q[$];
    int   fl[24];
    int   ftag;
    bit   loaded;
    int   e;
    int   rdy_e;
    int   last_val;
    int   checks;
    int   errors;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int frame_hd();
        int h = 0;
        for (int i = 0; i < 24; i++) if (fl[i] < 0) h |= (1 << i);
        return h;
    endfunction

    function automatic int frame_ch();
        int s = 0;
        for (int i = 0; i < 24; i++) s += (fl[i] < 0) ? -fl[i] : fl[i];
        return s;
    endfunction

    function automatic int frame_cm(input int c);
        int s = 0;
        for (int i = 0; i < 24; i++) s += ((c >> i) & 1) ? -fl[i] : fl[i];
        return s;
    endfunction

    task automatic load_frame(input logic [95:0] lv, input int tg);
        for (int i = 0; i < 24; i++) begin
            int v;
            v = $signed(lv[i*4 +: 4]);
`ifdef GOLAY24_DEC_LLR_SYM_CLIP_EN
            if (v == -8) v = -7;
`endif
            fl[i] = v;
        end
        ftag = tg & 1;
    endtask

    task automatic step(input bit en, input bit ld, input logic [95:0] lv,
                        input int tg, input bit v, input bit s, input bit ep,
                        input int c);
        bit   mrdy;
        exp_t x;
        @(negedge iclk);
        iclkena   = en;
        iload     = ld;
        illr      = lv;
        iltag     = tg[0:0];
        ival      = v;
        isop      = s;
        ieop      = ep;
        icand_dat = c[23:0];
        mrdy = loaded && (e >= rdy_e);
        #1 check("ordy", int'(ordy), int'(mrdy));
        @(posedge iclk);
        if (en) begin
            e++;
            if (v && mrdy)
                q.push_back('{e + 3, int'(s), int'(ep), ftag, frame_hd(),
                              frame_ch(), frame_cm(c), c & 24'hFFFFFF});
            if (ld) begin
                load_frame(lv, tg);
                loaded = 1'b1;
                rdy_e  = e + 3;
            end
        end
        #1;
        if (en) begin
            if (q.size() > 0 && q[0].due == e) begin
                x = q.pop_front();
                check("oval", int'(oval), 1);
                check("osop", int'(osop), x.sop);
                check("oeop", int'(oeop), x.eop);
                check("otag", int'(otag), x.tag);
                check("och_hd", int'(och_hd), x.hd);
                check("och_metric", int'($signed(och_metric)), x.chm);
                check("ocand_metric", int'($signed(ocand_metric)), x.cm);
                check("ocand_dat", int'(ocand_dat), x.dat);
                last_val = 1;
            end else begin
                check("oval_idle", int'(oval), 0);
                last_val = 0;
            end
        end else begin
            check("oval_hold", int'(oval), last_val);
        end
    endtask

    task automatic do_reset();
        @(negedge iclk);
        ireset = 1'b1;
        #1;
        check("rst_oval", int'(oval), 0);
        check("rst_ordy", int'(ordy), 0);
        check("rst_och_metric", int'(och_metric), 0);
        check("rst_ocand_metric", int'(ocand_metric), 0);
        check("rst_otag", int'(otag), 0);
        check("rst_och_hd", int'(och_hd), 0);
        q.delete();
        loaded   = 1'b0;
        last_val = 0;
        @(negedge iclk);
        ireset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, '0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [95:0] fa, fb, fm, lv;
        bit en, ld, v;
        int c;
        checks = 0;
        errors = 0;
        e      = 0;
        rdy_e  = 0;
        fa = {24{4'h7}};
        fm = {24{4'h8}};
        for (int i = 0; i < 24; i++) fb[i*4 +: 4] = (i % 2) ? 4'hD : 4'h5;

        do_reset();
        idle(3);

        step(1, 1, fa, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, '0, 0, 1, 1, 1, 0);
        step(1, 0, '0, 0, 1, 1, 1, 0);
        step(1, 0, '0, 0, 1, 1, 1, 24'hFFFFFF);
        idle(4);

        step(1, 1, fb, 0, 1, 1, 1, 24'h000F0F);
        for (int k = 0; k < 3; k++) step(1, 0, '0, 0, 1, 1, 0, 24'h123456);
        step(1, 0, '0, 0, 1, 1, 0, 24'hAAAAAA);
        step(1, 0, '0, 0, 1, 0, 1, 0);
        idle(5);

        step(1, 1, fm, 1, 0, 0, 0, 0);
        idle(3);
        step(1, 0, '0, 0, 1, 1, 1, 0);
        idle(5);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            en = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 19) == 0);
            lv = {$urandom, $urandom, $urandom};
            v  = $urandom_range(0, 1);
            c  = ($urandom_range(0, 3) == 0) ? frame_hd() : int'($urandom);
            step(en, ld, lv, int'($urandom_range(0, 1)), v,
                 $urandom_range(0, 1), $urandom_range(0, 1), c);
        end
        idle(6);
        check("drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
